// File: rtl/frame_buf_pkg.sv
// Shared constants, FSM encoding and pixel expansion helper for the camera
// write-side frame-buffer packer.
package frame_buf_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam int unsigned FRAME_PIX_DEF = 307200;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  // RGB565 -> 0x00RRGGBB, replicating the top bits into the low bits.
  function automatic logic [31:0] rgb565_to_word(input logic [15:0] pix);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = pix[15:11];
    g = pix[10:5];
    b = pix[4:0];
    return {8'h00, r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/cam_wr_pack_if.sv
// Frame-buffer write port: word/request towards the buffer, strobe/ready back.
interface cam_wr_pack_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fb_wr_en;
  logic                  mem_wr_rdy;
  logic                  wr_en_in;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (input fb_wr_en, input mem_wr_rdy, output wr_en_in, output wr_data);
  modport slave  (output fb_wr_en, output mem_wr_rdy, input wr_en_in, input wr_data);
endinterface

// File: rtl/pix_fifo.sv
// Synchronous show-ahead word FIFO; head reads as zero while empty.
module pix_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a full FIFO still takes the push.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cam_wr_pack.sv
// Packs RGB565 camera bytes into 32-bit words and streams them to the frame
// buffer through a small FIFO, tracking frame boundaries and pixel drops.
module cam_wr_pack
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_PIX  = FRAME_PIX_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wr_clk,
  input  logic        reset,
  input  logic        cam_pclk_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  cam_wr_pack_if.master fb,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow
);
  localparam int unsigned CNT_W = $clog2(FRAME_PIX + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q;
  logic                  vs_q;
  logic                  phase_q;
  logic [7:0]            hi_q;
  logic [CNT_W-1:0]      pix_cnt_q;
  logic                  done_q, err_q, ovf_q, wr_en_q;

  logic                  sof, byte_vld, push, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [FCW-1:0]        fifo_cnt;
  logic [DATA_WIDTH-1:0] word;

  assign sof      = cam_pclk_en & vs_q & ~cam_vsync;
  assign byte_vld = cam_pclk_en & cam_href;
  assign push     = (state_q == CAPTURE) & byte_vld & phase_q & ~sof;
  assign pop      = (fb.fb_wr_en == ASSERT_L) & fb.mem_wr_rdy & ~fifo_empty;
  assign drop     = push & fifo_full & ~pop;
  assign word     = DATA_WIDTH'(rgb565_to_word({hi_q, cam_data}));

  pix_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wr_clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (word),
    .data_o  (fb.wr_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign fb.wr_en_in = wr_en_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign overflow    = ovf_q;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q   <= WAIT_SOF;
      vs_q      <= 1'b0;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      pix_cnt_q <= '0;
      done_q    <= DEASSERT_H;
      err_q     <= DEASSERT_H;
      ovf_q     <= DEASSERT_H;
      wr_en_q   <= DEASSERT_L;
    end else begin
      done_q  <= DEASSERT_H;
      err_q   <= DEASSERT_H;
      wr_en_q <= fifo_empty ? DEASSERT_L : ASSERT_L;
      if (cam_pclk_en) vs_q <= cam_vsync;
      if (drop)        ovf_q <= ASSERT_H;
      case (state_q)
        WAIT_SOF: begin
          if (sof) begin
            state_q   <= CAPTURE;
            phase_q   <= 1'b0;
            pix_cnt_q <= '0;
          end
        end
        CAPTURE: begin
          if (sof) begin
            // Short frame: restart counting but keep already-queued words.
            err_q     <= ASSERT_H;
            phase_q   <= 1'b0;
            pix_cnt_q <= '0;
          end else if (byte_vld) begin
            if (!phase_q) begin
              hi_q    <= cam_data;
              phase_q <= 1'b1;
            end else begin
              phase_q   <= 1'b0;
              pix_cnt_q <= pix_cnt_q + 1'b1;
              if (pix_cnt_q == CNT_W'(FRAME_PIX - 1)) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_cnt == '0) begin
            done_q  <= ASSERT_H;
            state_q <= WAIT_SOF;
          end
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_wr_pack.sv
// Directed bench for cam_wr_pack: a FRAME_PIX=4 instance for frame flow and a
// FRAME_PIX=32 instance for overflow and mid-frame reset.
module tb_cam_wr_pack;
  import frame_buf_pkg::*;

  logic       wr_clk;
  logic       reset;
  logic       cam_pclk_en, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic       done_a, err_a, ovf_a, done_b, err_b, ovf_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cam_wr_pack_if #(.DATA_WIDTH(32)) fa ();
  cam_wr_pack_if #(.DATA_WIDTH(32)) fbb ();

  cam_wr_pack #(.DATA_WIDTH(32), .FRAME_PIX(4), .FIFO_DEPTH(8)) dut_a (
    .wr_clk(wr_clk), .reset(reset), .cam_pclk_en(cam_pclk_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .fb(fa),
    .frame_done(done_a), .frame_err(err_a), .overflow(ovf_a));

  cam_wr_pack #(.DATA_WIDTH(32), .FRAME_PIX(32), .FIFO_DEPTH(8)) dut_b (
    .wr_clk(wr_clk), .reset(reset), .cam_pclk_en(cam_pclk_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .fb(fbb),
    .frame_done(done_b), .frame_err(err_b), .overflow(ovf_b));

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // Monotonic event counters; tests compare deltas against a baseline.
  int unsigned pops_a = 0, ndone_a = 0, nerr_a = 0;
  int unsigned pops_b = 0, ndone_b = 0, nerr_b = 0;
  logic [31:0] log_a [64];

  always @(posedge wr_clk) begin
    if (!reset) begin
      if (!fa.fb_wr_en && fa.mem_wr_rdy && !dut_a.u_fifo.empty_o) begin
        log_a[pops_a[5:0]] = fa.wr_data;
        pops_a++;
      end
      if (!fbb.fb_wr_en && fbb.mem_wr_rdy && !dut_b.u_fifo.empty_o) pops_b++;
      if (done_a) ndone_a++;
      if (err_a)  nerr_a++;
      if (done_b) ndone_b++;
      if (err_b)  nerr_b++;
    end
  end

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_pclk_en = 1'b1; cam_href = 1'b1; cam_data = b;
    tick();
    cam_pclk_en = 1'b0; cam_href = 1'b0;
    tick();
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic sof();
    cam_pclk_en = 1'b1; cam_vsync = 1'b1; tick();
    cam_pclk_en = 1'b0; tick();
    cam_pclk_en = 1'b1; cam_vsync = 1'b0; tick();
    cam_pclk_en = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0;
  endtask

  int unsigned bp, bd, be;
  logic [5:0]  idx;
  logic [15:0] pix_t [4];
  logic [31:0] word_t [4];

  initial begin
    reset = 1'b1; cam_pclk_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    fa.fb_wr_en = 1'b1;  fa.mem_wr_rdy = 1'b0;
    fbb.fb_wr_en = 1'b1; fbb.mem_wr_rdy = 1'b0;
    tick(); tick();
    check("rst_state",    dut_a.state_q, WAIT_SOF);
    check("rst_wr_en_in", fa.wr_en_in, 1'b1);
    check("rst_wr_data",  fa.wr_data, 32'h0);
    check("rst_done",     done_a, 1'b0);
    check("rst_err",      err_a, 1'b0);
    check("rst_ovf",      ovf_a, 1'b0);
    check("rst_fifo_cnt", dut_a.u_fifo.count_o, 4'd0);
    reset = 1'b0;
    tick();

    // First pixel 0xF800 -> 0x00FF0000, request drops two edges after byte 2.
    sof();
    check("sof_capture", dut_a.state_q, CAPTURE);
    send_byte(8'hF8);
    cam_pclk_en = 1'b1; cam_href = 1'b1; cam_data = 8'h00;
    tick();
    cam_pclk_en = 1'b0; cam_href = 1'b0;
    check("push_cnt",        dut_a.u_fifo.count_o, 4'd1);
    check("push_word",       fa.wr_data, 32'h00FF0000);
    check("wr_en_in_1cyc",   fa.wr_en_in, 1'b1);
    check("pix_cnt_1",       dut_a.pix_cnt_q, 3'd1);
    tick();
    check("wr_en_in_2cyc",   fa.wr_en_in, 1'b0);

    // Full 4-pixel frame with the buffer always ready.
    do_reset();
    fa.fb_wr_en = 1'b0; fa.mem_wr_rdy = 1'b1;
    pix_t[0] = 16'h0000; word_t[0] = 32'h00000000;
    pix_t[1] = 16'hFFFF; word_t[1] = 32'h00FFFFFF;
    pix_t[2] = 16'h8410; word_t[2] = 32'h00848284;
    pix_t[3] = 16'h1234; word_t[3] = 32'h001045A5;
    bp = pops_a; bd = ndone_a;
    sof();
    for (int unsigned i = 0; i < 4; i++) send_pix(pix_t[i]);
    for (int unsigned i = 0; i < 10; i++) tick();
    check("frame_pops",  pops_a - bp, 4);
    check("frame_done1", ndone_a - bd, 1);
    check("frame_state", dut_a.state_q, WAIT_SOF);
    check("frame_wr_en", fa.wr_en_in, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 6'(bp + i);
      check($sformatf("frame_word%0d", i), log_a[idx], word_t[i]);
    end

    // Short frame: SOF after 3 pixels, then a complete 4-pixel frame.
    do_reset();
    bp = pops_a; bd = ndone_a; be = nerr_a;
    sof();
    for (int unsigned i = 0; i < 3; i++) send_pix(pix_t[i]);
    check("short_cnt3",  dut_a.pix_cnt_q, 3'd3);
    sof();
    check("short_err",   nerr_a - be, 1);
    check("short_cnt0",  dut_a.pix_cnt_q, 3'd0);
    check("short_state", dut_a.state_q, CAPTURE);
    check("short_nodone", ndone_a - bd, 0);
    for (int unsigned i = 0; i < 4; i++) send_pix(pix_t[i]);
    for (int unsigned i = 0; i < 10; i++) tick();
    check("short_done",  ndone_a - bd, 1);
    check("short_pops",  pops_a - bp, 7);
    check("short_err_once", nerr_a - be, 1);

    // Overflow: 20 pixels into an 8-deep FIFO with memory stalled.
    do_reset();
    fbb.fb_wr_en = 1'b0; fbb.mem_wr_rdy = 1'b0;
    bd = ndone_b; be = nerr_b;
    sof();
    for (int unsigned i = 0; i < 20; i++) begin
      send_pix((i == 0) ? 16'hF800 : 16'(i));
      if (i == 7) begin
        check("ovf_full_cnt", dut_b.u_fifo.count_o, 4'd8);
        check("ovf_not_yet",  ovf_b, 1'b0);
      end
    end
    check("ovf_held",    dut_b.u_fifo.count_o, 4'd8);
    check("ovf_flag",    ovf_b, 1'b1);
    check("ovf_counted", dut_b.pix_cnt_q, 6'd20);
    check("ovf_state",   dut_b.state_q, CAPTURE);
    check("ovf_head",    fbb.wr_data, 32'h00FF0000);

    // Pop three words, then reset with five buffered.
    fbb.mem_wr_rdy = 1'b1;
    tick(); tick(); tick();
    fbb.mem_wr_rdy = 1'b0;
    tick();
    check("pre_rst_cnt",  dut_b.u_fifo.count_o, 4'd5);
    check("pre_rst_head", fbb.wr_data, 32'h00000018);
    check("pre_rst_ovf",  ovf_b, 1'b1);
    check("pre_rst_req",  fbb.wr_en_in, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_mid_req",   fbb.wr_en_in, 1'b1);
    check("rst_mid_empty", dut_b.u_fifo.empty_o, 1'b1);
    check("rst_mid_ovf",   ovf_b, 1'b0);
    check("rst_mid_data",  fbb.wr_data, 32'h0);
    reset = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick();
    check("rst_mid_state",  dut_b.state_q, WAIT_SOF);
    check("rst_mid_nodone", ndone_b - bd, 0);
    check("rst_mid_noerr",  nerr_b - be, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
